perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent monitored channels, range 1..16.
REQ-002 Parameter CNT_WIDTH, default 64: width of every counter, range 8..64.
REQ-003 Parameter SATURATE, default 0: 0 = counters wrap on overflow, 1 = counters saturate at all-ones.
REQ-004 Parameter CH_AW, default 4: width of rd_ch; SHALL satisfy 2**CH_AW >= NUM_CH.
REQ-005 Clock and reset: one clock, CLK; reset RST is asynchronous and active-high.
REQ-006 CLK  in  1  sole clock; all state on rising edge.
REQ-007 RST  in  1  asynchronous active-high reset.
REQ-008 reset_count  in  1  synchronous clear of live counters, run trackers and ovf.
REQ-009 count_en  in  1  global count enable; 0 freezes live counters.
REQ-010 drive  in  NUM_CH  per-channel user-logic-driven flag.
REQ-011 req  in  NUM_CH  per-channel memory request (read or write).
REQ-012 rdy  in  NUM_CH  per-channel memory ready.
REQ-013 snap  in  1  copy all live counters into shadow registers.
REQ-014 rd_en  in  1  read request from shadow bank.
REQ-015 rd_ch  in  CH_AW  read channel index.
REQ-016 rd_sel  in  3  read counter select.
REQ-017 rd_valid  out  1  read data valid pulse.
REQ-018 rd_data  out  CNT_WIDTH  read data.
REQ-019 ovf  out  NUM_CH  sticky per-channel overflow flag (live counters).
REQ-020 snap_valid  out  1  shadow bank holds at least one snapshot.

Function
REQ-021 drive, req, rdy SHALL be registered one stage before classification; classification uses registered values only.
REQ-022 Per channel, exactly one class per cycle: idle = drive & ~req; hit = drive & req; miss = ~drive & req & ~rdy; conflict = ~drive & req & rdy; wait = ~drive & ~req.
REQ-023 Per-channel live counters: cycle_idle, cycle_hit, cycle_miss, cycle_conflict, cycle_wait, each +1 per cycle of its class when count_en=1.
REQ-024 num_miss SHALL increment on the first miss cycle of each run (miss now, not miss in previous registered cycle).
REQ-025 Miss-run tracker: run counter +1 per miss cycle, cleared on any non-miss cycle; max_miss_run updated to max(max_miss_run, run+1) on every miss cycle.
REQ-026 Previous-miss flag and run counter SHALL update regardless of count_en; only counter/max increments are gated.
REQ-027 Latency: input change at cycle n -> live counter reflects it after edge ending cycle n+1.
REQ-028 SATURATE=0: counter at all-ones + increment -> 0, ovf[ch] set; SATURATE=1: counter holds all-ones, ovf[ch] set.
REQ-029 ovf[ch] SHALL stay set until reset_count or RST.
REQ-030 reset_count has priority over increments; cleared counters read 0 next cycle.
REQ-031 snap SHALL capture all live counters of all channels atomically, pre-increment values of the same cycle; snap_valid set next cycle.
REQ-032 snap and reset_count same cycle: shadow gets pre-clear values; live counters cleared.
REQ-033 rd_sel map: 0 idle, 1 hit, 2 miss, 3 conflict, 4 wait, 5 num_miss, 6 max_miss_run, 7 returns 0.
REQ-034 rd_en at cycle n -> rd_valid=1 and rd_data at cycle n+1; rd_valid is a 1-cycle pulse; rd_data holds until next read.
REQ-035 rd_ch >= NUM_CH SHALL return 0 with rd_valid=1.
REQ-036 rd_en and snap same cycle: read returns previous shadow contents.
REQ-037 Back-to-back rd_en every cycle SHALL be supported at full throughput.

Reset
REQ-038 RST=1 asynchronously clears input stage, all live and shadow counters, run trackers, ovf, rd_valid, rd_data, snap_valid to 0.
REQ-039 RST deassertion: counting begins on the first edge with RST=0; first classification uses registered inputs of 0 (wait class).

Verification
REQ-040 NUM_CH=2, CNT_WIDTH=8: ch0 drive=1,req=1 for 10 cycles, snap, read sel 1 ch0 -> rd_data=10, rd_valid one cycle after rd_en.
REQ-041 ch1 miss pattern 3 on, 1 off, 5 on, snap -> num_miss=2, cycle_miss=8, max_miss_run=5.
REQ-042 SATURATE=0, 257 idle cycles ch0 -> idle=1, ovf[0]=1; SATURATE=1 -> idle=255, ovf[0]=1.
REQ-043 snap+reset_count same cycle after 20 wait cycles -> shadow wait=20, next snap after 3 cycles -> wait=3, ovf=0.
REQ-044 count_en=0 for 5 of 12 hit cycles -> hit=7; rd_ch=3 -> rd_data=0, rd_valid=1.
REQ-045 RST asserted mid-run asynchronously -> all outputs 0 before next edge; snap_valid=0.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Per-channel memory-interface performance counters with a snapshot shadow bank.
// Live counters classify each channel every cycle from registered drive/req/rdy,
// track miss runs, and can be copied atomically into a readable shadow bank.
module perf_counter_bank #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CNT_WIDTH = 64,
   parameter int unsigned SATURATE  = 0,
   parameter int unsigned CH_AW     = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 reset_count,
   input  logic                 count_en,
   input  logic [NUM_CH-1:0]    drive,
   input  logic [NUM_CH-1:0]    req,
   input  logic [NUM_CH-1:0]    rdy,
   input  logic                 snap,
   input  logic                 rd_en,
   input  logic [CH_AW-1:0]     rd_ch,
   input  logic [2:0]           rd_sel,
   output logic                 rd_valid,
   output logic [CNT_WIDTH-1:0] rd_data,
   output logic [NUM_CH-1:0]    ovf,
   output logic                 snap_valid
);

   // Counter slots: 0 idle, 1 hit, 2 miss, 3 conflict, 4 wait, 5 num_miss, 6 max_miss_run
   localparam int unsigned NUM_CNT  = 7;
   localparam int unsigned NUM_INC  = 6;
   localparam int unsigned IDX_MAX  = 6;
   localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

   logic [NUM_CH-1:0]    drive_q;
   logic [NUM_CH-1:0]    req_q;
   logic [NUM_CH-1:0]    rdy_q;
   logic [CNT_WIDTH-1:0] live   [NUM_CH][NUM_CNT];
   logic [CNT_WIDTH-1:0] shadow [NUM_CH][NUM_CNT];
   logic [CNT_WIDTH-1:0] run    [NUM_CH];
   logic [NUM_CH-1:0]    prev_miss;
   logic [NUM_CH-1:0]    is_miss;
   logic [NUM_CNT-1:0]   inc      [NUM_CH];
   logic [CNT_WIDTH-1:0] max_cand [NUM_CH];
   logic [CNT_WIDTH-1:0] rd_mux;

   // Input stage: classification only ever sees registered flags
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         drive_q <= '0;
         req_q   <= '0;
         rdy_q   <= '0;
      end else begin
         drive_q <= drive;
         req_q   <= req;
         rdy_q   <= rdy;
      end
   end

   // Per-channel class decode, first-miss detect and run-length candidate
   always_comb begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
         is_miss[ch]  = ~drive_q[ch] & req_q[ch] & ~rdy_q[ch];
         inc[ch]      = '0;
         inc[ch][0]   = drive_q[ch] & ~req_q[ch];
         inc[ch][1]   = drive_q[ch] & req_q[ch];
         inc[ch][2]   = is_miss[ch];
         inc[ch][3]   = ~drive_q[ch] & req_q[ch] & rdy_q[ch];
         inc[ch][4]   = ~drive_q[ch] & ~req_q[ch];
         inc[ch][5]   = is_miss[ch] & ~prev_miss[ch];
         inc[ch][6]   = is_miss[ch];
         // Run length is clamped so a pathological run cannot alias to a small max
         max_cand[ch] = (run[ch] == ALL_ONES) ? ALL_ONES : run[ch] + CNT_WIDTH'(1);
      end
   end

   // Live counters, run trackers and sticky overflow; reset_count wins over increments
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            for (int unsigned k = 0; k < NUM_CNT; k++) live[ch][k] <= '0;
            run[ch] <= '0;
         end
         prev_miss <= '0;
         ovf       <= '0;
      end else if (reset_count) begin
         for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            for (int unsigned k = 0; k < NUM_CNT; k++) live[ch][k] <= '0;
            run[ch] <= '0;
         end
         prev_miss <= '0;
         ovf       <= '0;
      end else begin
         for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            // Run tracking is independent of count_en so gating cannot split a run
            prev_miss[ch] <= is_miss[ch];
            run[ch]       <= is_miss[ch] ? max_cand[ch] : '0;
            if (count_en) begin
               for (int unsigned k = 0; k < NUM_INC; k++) begin
                  if (inc[ch][k]) begin
                     if (live[ch][k] == ALL_ONES) begin
                        ovf[ch]     <= 1'b1;
                        live[ch][k] <= (SATURATE != 0) ? ALL_ONES : '0;
                     end else begin
                        live[ch][k] <= live[ch][k] + CNT_WIDTH'(1);
                     end
                  end
               end
               if (inc[ch][IDX_MAX] && (max_cand[ch] > live[ch][IDX_MAX]))
                  live[ch][IDX_MAX] <= max_cand[ch];
            end
         end
      end
   end

   // Shadow bank captures pre-increment live values of all channels at once
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned ch = 0; ch < NUM_CH; ch++)
            for (int unsigned k = 0; k < NUM_CNT; k++) shadow[ch][k] <= '0;
         snap_valid <= 1'b0;
      end else if (snap) begin
         for (int unsigned ch = 0; ch < NUM_CH; ch++)
            for (int unsigned k = 0; k < NUM_CNT; k++) shadow[ch][k] <= live[ch][k];
         snap_valid <= 1'b1;
      end
   end

   // Read select; unmapped channel or rd_sel=7 yields zero
   always_comb begin
      rd_mux = '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++)
         for (int unsigned k = 0; k < NUM_CNT; k++)
            if ((rd_ch == CH_AW'(ch)) && (rd_sel == 3'(k))) rd_mux = shadow[ch][k];
   end

   // Read port: one-cycle valid pulse, data held until the next read
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= rd_mux;
      end
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: wrapping and saturating instances share stimulus
// and are checked every cycle against a behavioural model of the counter rules.
module tb_perf_counter_bank;

   localparam int NCH  = 2;
   localparam int MAXV = 255;

   logic       CLK, RST, reset_count, count_en, snap, rd_en;
   logic [1:0] drive, req, rdy, rd_ch;
   logic [2:0] rd_sel;
   logic       rv0, rv1, sv0, sv1;
   logic [7:0] rd0, rd1;
   logic [1:0] ovf0, ovf1;

   int total = 0;
   int bad   = 0;

   // model state; instance 0 wraps, instance 1 saturates
   int         cnt [2][NCH][7];
   int         shd [2][NCH][7];
   int         run [NCH];
   bit         pmiss [NCH];
   logic [1:0] m_ovf [2];
   logic [1:0] qd, qr, qy;
   logic       m_rd_valid, m_snap_valid;
   int         m_rd_data [2];

   perf_counter_bank #(.NUM_CH(2), .CNT_WIDTH(8), .SATURATE(0), .CH_AW(2)) u_wrap (
      .CLK(CLK), .RST(RST), .reset_count(reset_count), .count_en(count_en),
      .drive(drive), .req(req), .rdy(rdy), .snap(snap), .rd_en(rd_en),
      .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_valid(rv0), .rd_data(rd0),
      .ovf(ovf0), .snap_valid(sv0));

   perf_counter_bank #(.NUM_CH(2), .CNT_WIDTH(8), .SATURATE(1), .CH_AW(2)) u_sat (
      .CLK(CLK), .RST(RST), .reset_count(reset_count), .count_en(count_en),
      .drive(drive), .req(req), .rdy(rdy), .snap(snap), .rd_en(rd_en),
      .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_valid(rv1), .rd_data(rd1),
      .ovf(ovf1), .snap_valid(sv1));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++)
         for (int ch = 0; ch < NCH; ch++)
            for (int k = 0; k < 7; k++) begin
               cnt[s][ch][k] = 0;
               shd[s][ch][k] = 0;
            end
      for (int ch = 0; ch < NCH; ch++) begin
         run[ch]   = 0;
         pmiss[ch] = 0;
      end
      m_ovf[0] = '0; m_ovf[1] = '0;
      m_rd_data[0] = 0; m_rd_data[1] = 0;
      m_rd_valid = 1'b0; m_snap_valid = 1'b0;
      qd = '0; qr = '0; qy = '0;
   endtask

   function automatic int clamp(input int v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   task automatic bump(input int s, input int ch, input int k);
      if (cnt[s][ch][k] == MAXV) begin
         m_ovf[s][ch]  = 1'b1;
         cnt[s][ch][k] = (s == 1) ? MAXV : 0;
      end else begin
         cnt[s][ch][k]++;
      end
   endtask

   // One clock edge of the counter rules, applied to the inputs present at the edge
   task automatic model_step();
      int cls;
      bit miss;
      if (RST) begin
         model_reset();
         return;
      end
      m_rd_valid = rd_en;
      if (rd_en) begin
         for (int s = 0; s < 2; s++) begin
            if ((int'(rd_ch) < NCH) && (rd_sel != 3'd7)) m_rd_data[s] = shd[s][rd_ch][rd_sel];
            else m_rd_data[s] = 0;
         end
      end
      if (snap) begin
         shd = cnt;
         m_snap_valid = 1'b1;
      end
      if (reset_count) begin
         for (int s = 0; s < 2; s++)
            for (int ch = 0; ch < NCH; ch++)
               for (int k = 0; k < 7; k++) cnt[s][ch][k] = 0;
         for (int ch = 0; ch < NCH; ch++) begin
            run[ch] = 0;
            pmiss[ch] = 0;
         end
         m_ovf[0] = '0; m_ovf[1] = '0;
      end else begin
         for (int ch = 0; ch < NCH; ch++) begin
            if (qd[ch]) cls = qr[ch] ? 1 : 0;
            else if (!qr[ch]) cls = 4;
            else cls = qy[ch] ? 3 : 2;
            miss = (cls == 2);
            if (count_en) begin
               for (int s = 0; s < 2; s++) begin
                  bump(s, ch, cls);
                  if (miss && !pmiss[ch]) bump(s, ch, 5);
                  if (miss && clamp(run[ch] + 1) > cnt[s][ch][6]) cnt[s][ch][6] = clamp(run[ch] + 1);
               end
            end
            pmiss[ch] = miss;
            run[ch]   = miss ? clamp(run[ch] + 1) : 0;
         end
      end
      qd = drive; qr = req; qy = rdy;
   endtask

   task automatic step();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic rd(input int ch, input int sel, input int e0, input int e1, input string nm);
      rd_en = 1'b1; rd_ch = 2'(ch); rd_sel = 3'(sel);
      step();
      rd_en = 1'b0;
      chk({nm, "_valid"}, 64'(rv0), 64'd1);
      chk(nm, 64'(rd0), 64'(e0));
      chk({nm, "_sat"}, 64'(rd1), 64'(e1));
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge CLK) begin
      chk("rd_valid_w", 64'(rv0), 64'(m_rd_valid));
      chk("rd_valid_s", 64'(rv1), 64'(m_rd_valid));
      chk("rd_data_w", 64'(rd0), 64'(m_rd_data[0]));
      chk("rd_data_s", 64'(rd1), 64'(m_rd_data[1]));
      chk("ovf_w", 64'(ovf0), 64'(m_ovf[0]));
      chk("ovf_s", 64'(ovf1), 64'(m_ovf[1]));
      chk("snap_valid_w", 64'(sv0), 64'(m_snap_valid));
      chk("snap_valid_s", 64'(sv1), 64'(m_snap_valid));
   end

   initial begin
      RST = 1'b1; reset_count = 1'b0; count_en = 1'b0; snap = 1'b0; rd_en = 1'b0;
      drive = '0; req = '0; rdy = '0; rd_ch = '0; rd_sel = '0;
      model_reset();
      repeat (3) step();
      chk("rst_rd_valid", 64'(rv0), 64'd0);
      chk("rst_rd_data", 64'(rd0), 64'd0);
      chk("rst_ovf", 64'(ovf0), 64'd0);
      chk("rst_snap_valid", 64'(sv0), 64'd0);
      RST = 1'b0;
      count_en = 1'b1;

      // ch0 ten hit cycles; ch1 miss pattern 3 on, 1 off, 5 on
      for (int c = 0; c < 12; c++) begin
         reset_count = (c == 0);
         drive[0] = (c < 10); req[0] = (c < 10);
         drive[1] = 1'b0; rdy[1] = 1'b0; req[1] = (c < 9) && (c != 3);
         snap = (c == 11);
         step();
      end
      reset_count = 1'b0; snap = 1'b0; drive = '0; req = '0;
      chk("snap_valid_set", 64'(sv0), 64'd1);
      rd(0, 1, 10, 10, "hit10");
      step();
      chk("rd_valid_pulse", 64'(rv0), 64'd0);
      rd_en = 1'b1; rd_ch = 2'd1; rd_sel = 3'd2; step();
      chk("b2b_miss", 64'(rd0), 64'd8); chk("b2b_valid0", 64'(rv0), 64'd1);
      rd_ch = 2'd0; rd_sel = 3'd7; step();
      chk("b2b_sel7", 64'(rd0), 64'd0); chk("b2b_valid1", 64'(rv0), 64'd1);
      rd_ch = 2'd1; rd_sel = 3'd5; step();
      chk("b2b_num_miss", 64'(rd0), 64'd2);
      rd_sel = 3'd6; step();
      chk("b2b_max_run", 64'(rd0), 64'd5);
      rd_en = 1'b0; step();
      chk("rd_hold_data", 64'(rd0), 64'd5); chk("rd_hold_valid", 64'(rv0), 64'd0);

      // twelve hit cycles with count_en low for five counting edges
      for (int c = 0; c < 14; c++) begin
         reset_count = (c == 0);
         drive[0] = (c < 12); req[0] = (c < 12);
         count_en = !((c >= 3) && (c <= 7));
         snap = (c == 13);
         step();
      end
      reset_count = 1'b0; snap = 1'b0; count_en = 1'b1; drive = '0; req = '0;
      rd(0, 1, 7, 7, "hit_gated");
      rd(3, 1, 0, 0, "rd_ch_oob");

      // 257 idle cycles on ch0: wrap vs saturate
      for (int c = 0; c < 260; c++) begin
         reset_count = (c == 0);
         drive[0] = (c < 257); req[0] = 1'b0;
         snap = (c == 259);
         step();
      end
      reset_count = 1'b0; snap = 1'b0; drive = '0;
      chk("ovf0_wrap", 64'(ovf0[0]), 64'd1);
      chk("ovf0_sat", 64'(ovf1[0]), 64'd1);
      rd(0, 0, 1, 255, "idle257");

      // snap and reset_count together after 20 wait cycles
      for (int c = 0; c < 26; c++) begin
         reset_count = (c == 0) || (c == 21);
         snap  = (c == 21) || (c == 25);
         rd_en = (c == 22) || (c == 25); rd_ch = 2'd0; rd_sel = 3'd4;
         step();
         if (c == 21) chk("ovf_cleared", 64'(ovf0), 64'd0);
         if (c == 22) chk("wait20", 64'(rd0), 64'd20);
         if (c == 25) chk("rd_with_snap", 64'(rd0), 64'd20);
      end
      reset_count = 1'b0; snap = 1'b0; rd_en = 1'b0;
      rd(0, 4, 3, 3, "wait3");

      // asynchronous reset mid-cycle
      #2 RST = 1'b1;
      model_reset();
      #1;
      chk("arst_rd_valid", 64'(rv0), 64'd0);
      chk("arst_rd_data", 64'({rd0, rd1}), 64'd0);
      chk("arst_ovf", 64'({ovf0, ovf1}), 64'd0);
      chk("arst_snap_valid", 64'({sv0, sv1}), 64'd0);
      step();
      RST = 1'b0;

      // randomized traffic checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         drive = 2'($urandom) & 2'($urandom);
         req   = 2'($urandom);
         rdy   = 2'($urandom);
         count_en    = ($urandom_range(0, 9) != 0);
         reset_count = ($urandom_range(0, 199) == 0);
         snap  = ($urandom_range(0, 7) == 0);
         rd_en = 1'($urandom_range(0, 1));
         rd_ch = 2'($urandom);
         rd_sel = 3'($urandom);
         step();
      end
      rd_en = 1'b0; snap = 1'b0; reset_count = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
